// File: rtl/satd_ctrl.sv
// satd_ctrl: sequencer for the 8x8 SATD datapath (row fetch, diff enable, sum).
// Build option SATD_CTRL_ROUND_EN: report (acc + 2) >> 2 instead of the raw sum.
module satd_ctrl #(
    parameter int ROWS     = 8,
    parameter int ADDR_W   = 6,
    parameter int SUM_IN_W = 16,
    parameter int SATD_W   = 19
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    output logic                busy,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic                diff_en,
    input  logic                row_valid,
    input  logic [SUM_IN_W-1:0] row_sum,
    output logic                done,
    output logic [SATD_W-1:0]   satd
);

    localparam int CNT_W = $clog2(ROWS) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ROWS);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  base_q;
    logic [CNT_W-1:0]   issue_cnt;
    logic [CNT_W-1:0]   ret_cnt;
    logic [SATD_W-1:0]  acc;

    logic               take;
    logic [CNT_W-1:0]   ret_nxt;
    logic [SATD_W-1:0]  acc_nxt;
    logic               ret_done;
    logic               last_iss;
    logic [SATD_W-1:0]  satd_fin;

    // Accept a row result only while a block is in flight and short of ROWS.
    always_comb begin
        take     = 1'b0;
        ret_nxt  = ret_cnt;
        acc_nxt  = acc;
        if ((state == ISSUE || state == DRAIN) && row_valid
            && (ret_cnt < LAST)) begin
            take = 1'b1;
        end
        if (take) begin
            ret_nxt = ret_cnt + ONE;
            acc_nxt = acc + SATD_W'(row_sum);
        end
        ret_done = (ret_nxt == LAST);
        last_iss = (issue_cnt == LAST);
    end

`ifdef SATD_CTRL_ROUND_EN
    logic [SATD_W:0] rnd;

    // Hadamard normalisation; one extra bit keeps the +2 from overflowing.
    always_comb begin
        rnd      = {1'b0, acc_nxt} + (SATD_W+1)'(2);
        satd_fin = SATD_W'(rnd >> 2);
    end
`else
    assign satd_fin = acc_nxt;
`endif

    // Block control FSM; all outputs are registered here.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            base_q    <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            acc       <= '0;
            busy      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            done      <= 1'b0;
            satd      <= '0;
        end else begin
            rd_en <= 1'b0;
            done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= ISSUE;
                        base_q    <= base_addr;
                        busy      <= 1'b1;
                        rd_en     <= 1'b1;
                        rd_addr   <= base_addr;
                        issue_cnt <= ONE;
                        ret_cnt   <= '0;
                        acc       <= '0;
                    end
                end
                ISSUE: begin
                    acc     <= acc_nxt;
                    ret_cnt <= ret_nxt;
                    if (!last_iss) begin
                        rd_en     <= 1'b1;
                        rd_addr   <= base_q + ADDR_W'(issue_cnt);
                        issue_cnt <= issue_cnt + ONE;
                    end else if (ret_done) begin
                        state <= DONE;
                        done  <= 1'b1;
                        satd  <= satd_fin;
                    end else begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    acc     <= acc_nxt;
                    ret_cnt <= ret_nxt;
                    if (ret_done) begin
                        state <= DONE;
                        done  <= 1'b1;
                        satd  <= satd_fin;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Difference stage runs one cycle behind each fetch (read latency 1).
    always_ff @(posedge CLK) begin
        if (RST) begin
            diff_en <= 1'b0;
        end else begin
            diff_en <= rd_en;
        end
    end

endmodule
